// File: rtl/branch_stack.sv
// Branch checkpoint stack: allocates one-hot branch tags, snapshots free-list head and ROB tail,
// and on resolve reports correct/mispredict with the restore point and the tags to squash.
`ifndef BR_STATE_W
`define BR_STATE_W 2
`endif
`ifndef BR_NONE
`define BR_NONE 2'd0
`endif
`ifndef BR_PR_CORRECT
`define BR_PR_CORRECT 2'd1
`endif
`ifndef BR_PR_WRONG
`define BR_PR_WRONG 2'd2
`endif

module branch_stack #(
    parameter int unsigned BR_DEPTH = 4,
    parameter int unsigned HD_W     = 5,
    parameter int unsigned ROB_W    = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dispatch_br_i,
    input  logic [HD_W-1:0]        fl_head_i,
    input  logic [ROB_W-1:0]       rob_tail_i,
    input  logic                   br_resolve_en_i,
    input  logic [BR_DEPTH-1:0]    br_resolve_tag_i,
    input  logic                   br_mispredict_i,
    output logic                   br_full_o,
    output logic [BR_DEPTH-1:0]    br_tag_o,
    output logic [BR_DEPTH-1:0]    br_mask_o,
    output logic [`BR_STATE_W-1:0] br_state_o,
    output logic [HD_W-1:0]        rc_head_o,
    output logic [ROB_W-1:0]       rc_rob_tail_o,
    output logic [BR_DEPTH-1:0]    squash_mask_o
);

    logic [BR_DEPTH-1:0] valid_q, valid_d;
    logic [HD_W-1:0]     fl_head_q  [BR_DEPTH];
    logic [HD_W-1:0]     fl_head_d  [BR_DEPTH];
    logic [ROB_W-1:0]    rob_tail_q [BR_DEPTH];
    logic [ROB_W-1:0]    rob_tail_d [BR_DEPTH];
    logic [BR_DEPTH-1:0] dep_mask_q [BR_DEPTH];
    logic [BR_DEPTH-1:0] dep_mask_d [BR_DEPTH];

    logic                tag_onehot_c;
    logic                res_valid_c;
    logic                correct_c;
    logic                wrong_c;
    logic                full_c;
    logic                alloc_en_c;
    logic [BR_DEPTH-1:0] alloc_oh_c;
    logic [BR_DEPTH-1:0] clear_c;
    logic [BR_DEPTH-1:0] squash_c;
    logic [HD_W-1:0]     rc_head_c;
    logic [ROB_W-1:0]    rc_tail_c;

    // Resolve qualification, restore values and squash set; only valid entries contribute.
    always_comb begin
        tag_onehot_c = (br_resolve_tag_i != '0) &&
                       ((br_resolve_tag_i & (br_resolve_tag_i - BR_DEPTH'(1))) == '0);
        res_valid_c  = br_resolve_en_i && tag_onehot_c && ((br_resolve_tag_i & valid_q) != '0);
        wrong_c      = res_valid_c && br_mispredict_i;
        correct_c    = res_valid_c && !br_mispredict_i;
        squash_c     = '0;
        rc_head_c    = '0;
        rc_tail_c    = '0;
        if (wrong_c) begin
            squash_c = br_resolve_tag_i;
            for (int i = 0; i < int'(BR_DEPTH); i++) begin
                if (valid_q[i] && ((dep_mask_q[i] & br_resolve_tag_i) != '0)) begin
                    squash_c[i] = 1'b1;
                end
                if (br_resolve_tag_i[i]) begin
                    rc_head_c = fl_head_q[i];
                    rc_tail_c = rob_tail_q[i];
                end
            end
        end
    end

    // Allocation sees registered fullness only, so a same-cycle free is not reused.
    always_comb begin
        full_c     = &valid_q;
        alloc_en_c = dispatch_br_i && !full_c && !wrong_c && !rst;
        alloc_oh_c = alloc_en_c ? (~valid_q & (valid_q + BR_DEPTH'(1))) : '0;
    end

    always_comb begin
        clear_c = '0;
        if (correct_c) begin
            clear_c = br_resolve_tag_i;
        end else if (wrong_c) begin
            clear_c = squash_c;
        end
        valid_d = (valid_q & ~clear_c) | alloc_oh_c;
        for (int i = 0; i < int'(BR_DEPTH); i++) begin
            fl_head_d[i]  = fl_head_q[i];
            rob_tail_d[i] = rob_tail_q[i];
            dep_mask_d[i] = dep_mask_q[i] & ~clear_c;
            if (alloc_oh_c[i]) begin
                fl_head_d[i]  = fl_head_i;
                rob_tail_d[i] = rob_tail_i;
                dep_mask_d[i] = valid_q & ~clear_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < int'(BR_DEPTH); i++) begin
                fl_head_q[i]  <= '0;
                rob_tail_q[i] <= '0;
                dep_mask_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < int'(BR_DEPTH); i++) begin
                fl_head_q[i]  <= fl_head_d[i];
                rob_tail_q[i] <= rob_tail_d[i];
                dep_mask_q[i] <= dep_mask_d[i];
            end
        end
    end

    always_comb begin
        br_full_o     = full_c;
        br_mask_o     = valid_q;
        br_tag_o      = alloc_oh_c;
        br_state_o    = `BR_NONE;
        if (wrong_c) begin
            br_state_o = `BR_PR_WRONG;
        end else if (correct_c) begin
            br_state_o = `BR_PR_CORRECT;
        end
        rc_head_o     = rc_head_c;
        rc_rob_tail_o = rc_tail_c;
        squash_mask_o = squash_c;
    end

endmodule

// File: tb/tb_branch_stack.sv
// Scoreboard bench for branch_stack: an age-ordered list of outstanding branches predicts each
// cycle's outputs; a monitor compares them at the falling edge.
`ifndef BR_STATE_W
`define BR_STATE_W 2
`endif
`ifndef BR_NONE
`define BR_NONE 2'd0
`endif
`ifndef BR_PR_CORRECT
`define BR_PR_CORRECT 2'd1
`endif
`ifndef BR_PR_WRONG
`define BR_PR_WRONG 2'd2
`endif

module tb_branch_stack;
    localparam int unsigned BR_DEPTH = 4;
    localparam int unsigned HD_W     = 5;
    localparam int unsigned ROB_W    = 5;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   dispatch_br_i;
    logic [HD_W-1:0]        fl_head_i;
    logic [ROB_W-1:0]       rob_tail_i;
    logic                   br_resolve_en_i;
    logic [BR_DEPTH-1:0]    br_resolve_tag_i;
    logic                   br_mispredict_i;
    logic                   br_full_o;
    logic [BR_DEPTH-1:0]    br_tag_o;
    logic [BR_DEPTH-1:0]    br_mask_o;
    logic [`BR_STATE_W-1:0] br_state_o;
    logic [HD_W-1:0]        rc_head_o;
    logic [ROB_W-1:0]       rc_rob_tail_o;
    logic [BR_DEPTH-1:0]    squash_mask_o;

    always #5 clk = ~clk;

    typedef struct {
        int               idx;
        logic [HD_W-1:0]  hd;
        logic [ROB_W-1:0] rt;
    } br_t;

    typedef struct packed {
        logic [BR_DEPTH-1:0]    tag;
        logic                   full;
        logic [BR_DEPTH-1:0]    mask;
        logic [`BR_STATE_W-1:0] state;
        logic [HD_W-1:0]        hd;
        logic [ROB_W-1:0]       rt;
        logic [BR_DEPTH-1:0]    sq;
    } exp_t;

    br_t  age_q[$];
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    branch_stack #(.BR_DEPTH(BR_DEPTH), .HD_W(HD_W), .ROB_W(ROB_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .dispatch_br_i    (dispatch_br_i),
        .fl_head_i        (fl_head_i),
        .rob_tail_i       (rob_tail_i),
        .br_resolve_en_i  (br_resolve_en_i),
        .br_resolve_tag_i (br_resolve_tag_i),
        .br_mispredict_i  (br_mispredict_i),
        .br_full_o        (br_full_o),
        .br_tag_o         (br_tag_o),
        .br_mask_o        (br_mask_o),
        .br_state_o       (br_state_o),
        .rc_head_o        (rc_head_o),
        .rc_rob_tail_o    (rc_rob_tail_o),
        .squash_mask_o    (squash_mask_o)
    );

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Drive one cycle of stimulus, predict that cycle's outputs, then advance the model.
    task automatic step(input logic r, input logic disp, input logic [HD_W-1:0] hd,
                        input logic [ROB_W-1:0] rt, input logic ren,
                        input logic [BR_DEPTH-1:0] tag, input logic mis);
        exp_t                e;
        logic [BR_DEPTH-1:0] live;
        int                  pos;
        int                  fr;
        @(posedge clk);
        #1;
        rst              = r;
        dispatch_br_i    = disp;
        fl_head_i        = hd;
        rob_tail_i       = rt;
        br_resolve_en_i  = ren;
        br_resolve_tag_i = tag;
        br_mispredict_i  = mis;
        e = '0;
        if (r) begin
            age_q.delete();
            sb_q.push_back(e);
            return;
        end
        live = '0;
        foreach (age_q[k]) live[age_q[k].idx] = 1'b1;
        e.mask = live;
        e.full = (age_q.size() == int'(BR_DEPTH));
        pos = -1;
        if (ren && $countones(tag) == 1) begin
            foreach (age_q[k]) if (tag[age_q[k].idx]) pos = k;
        end
        fr = -1;
        if (pos >= 0 && mis) begin
            e.state = `BR_PR_WRONG;
            e.hd    = age_q[pos].hd;
            e.rt    = age_q[pos].rt;
            for (int k = pos; k < int'(age_q.size()); k++) e.sq[age_q[k].idx] = 1'b1;
        end else begin
            if (pos >= 0) e.state = `BR_PR_CORRECT;
            if (disp && !e.full) begin
                for (int i = int'(BR_DEPTH) - 1; i >= 0; i--) if (!live[i]) fr = i;
                e.tag[fr] = 1'b1;
            end
        end
        sb_q.push_back(e);
        if (pos >= 0 && mis) begin
            while (int'(age_q.size()) > pos) void'(age_q.pop_back());
        end else begin
            if (pos >= 0) age_q.delete(pos);
            if (fr >= 0) age_q.push_back('{fr, hd, rt});
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic disp(input logic [HD_W-1:0] hd);
        step(1'b0, 1'b1, hd, ROB_W'($urandom), 1'b0, '0, 1'b0);
    endtask

    task automatic resolve(input logic [BR_DEPTH-1:0] tag, input logic mis, input logic d);
        step(1'b0, d, HD_W'($urandom), ROB_W'($urandom), 1'b1, tag, mis);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("br_tag_o",      br_tag_o,      e.tag);
                chk("br_full_o",     br_full_o,     e.full);
                chk("br_mask_o",     br_mask_o,     e.mask);
                chk("br_state_o",    br_state_o,    e.state);
                chk("rc_head_o",     rc_head_o,     e.hd);
                chk("rc_rob_tail_o", rc_rob_tail_o, e.rt);
                chk("squash_mask_o", squash_mask_o, e.sq);
            end
        end
    end

    initial begin : stimulus
        logic [BR_DEPTH-1:0] t;
        rst              = 1'b1;
        dispatch_br_i    = 1'b0;
        fl_head_i        = '0;
        rob_tail_i       = '0;
        br_resolve_en_i  = 1'b0;
        br_resolve_tag_i = '0;
        br_mispredict_i  = 1'b0;

        // reset held with a dispatch request pending
        step(1'b1, 1'b1, 5'd1, 5'd1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 5'd2, 5'd2, 1'b1, 4'b0001, 1'b1);

        // fill, then overflow attempt
        disp(5'd3); disp(5'd7); disp(5'd9); disp(5'd12);
        disp(5'd20);
        resolve(4'b0010, 1'b1, 1'b0);
        idle();

        // correct resolve while full with a dispatch in the same cycle
        disp(5'd4); disp(5'd5); disp(5'd6);
        resolve(4'b0001, 1'b0, 1'b1);
        idle();
        disp(5'd8);
        resolve(4'b0010, 1'b1, 1'b0);
        idle();

        // dispatch dropped by a simultaneous mispredict
        disp(5'd10); disp(5'd11);
        resolve(4'b0010, 1'b1, 1'b1);
        idle();
        idle();

        // invalid and non-one-hot resolves
        resolve(4'b0100, 1'b0, 1'b0);
        resolve(4'b0011, 1'b1, 1'b0);
        idle();

        // async reset with three outstanding
        disp(5'd13); disp(5'd14);
        step(1'b1, 1'b1, 5'd15, 5'd15, 1'b1, 4'b0001, 1'b1);
        idle();
        idle();

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0 || age_q.size() == 0)
                t = BR_DEPTH'($urandom_range(0, 15));
            else
                t = BR_DEPTH'(1) << age_q[$urandom_range(0, age_q.size() - 1)].idx;
            step($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0, HD_W'($urandom),
                 ROB_W'($urandom), $urandom_range(0, 2) == 0, t, $urandom_range(0, 2) == 0);
        end
        idle();

        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
